// File: rtl/multitrack_record_core_if.sv
// rtl/multitrack_record_core_if.sv - SDRAM request and audio receive bundle for the recorder
interface multitrack_record_core_if #(
    parameter int ADDR_W = 23
);
    logic              record_read;
    logic              record_write;
    logic [ADDR_W-1:0] record_addr;
    logic [31:0]       record_readdata;
    logic [31:0]       record_writedata;
    logic              record_sdram_finished;
    logic              record_audio_ready;
    logic [31:0]       record_audio_data;
    logic              record_audio_valid;

    modport master (
        output record_read, record_write, record_addr, record_writedata, record_audio_ready,
        input  record_readdata, record_sdram_finished, record_audio_data, record_audio_valid
    );

    modport slave (
        input  record_read, record_write, record_addr, record_writedata, record_audio_ready,
        output record_readdata, record_sdram_finished, record_audio_data, record_audio_valid
    );
endinterface

// File: rtl/multitrack_record_core.sv
// rtl/multitrack_record_core.sv - multitrack SDRAM recorder with saturating overdub mixing
module multitrack_record_core #(
    parameter int ADDR_W  = 23,
    parameter int NUM_TRK = 3
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      record_start,
    input  logic [NUM_TRK*ADDR_W-1:0] record_select,
    input  logic [NUM_TRK-2:0]        record_mask,
    input  logic                      record_mic_en,
    input  logic [ADDR_W-1:0]         record_length,
    input  logic                      record_pause,
    input  logic                      record_stop,
    output logic                      record_done,
    output logic                      record_busy,
    output logic [ADDR_W-1:0]         record_count,
    multitrack_record_core_if.master  bus
);
    localparam int IDX_W = $clog2(NUM_TRK + 1);
    localparam logic [IDX_W-1:0] SRC_END = IDX_W'(NUM_TRK);

    typedef enum logic [2:0] {S_IDLE, S_AUDIO, S_SRC, S_WRITE, S_PAUSED, S_DONE} state_t;

    state_t                    state, state_next, resume_state;
    logic [NUM_TRK*ADDR_W-1:0] sel_q;
    logic [NUM_TRK-2:0]        mask_q;
    logic                      mic_q;
    logic [ADDR_W-1:0]         len_q;
    logic                      stop_pending;
    logic [IDX_W-1:0]          src_idx;
    logic signed [18:0]        acc_l, acc_r;

    logic                      stop_any;
    logic [ADDR_W-1:0]         cnt_next, src_base;
    logic [IDX_W-1:0]          start_src, first_src, after_src;
    logic do_start, begin_sample, take_audio, issue_read, take_read, issue_write, take_write, go_done;

    // Lowest enabled source slot at or above 'from'; SRC_END when none remain.
    function automatic logic [IDX_W-1:0] next_src(input logic [NUM_TRK-2:0] m, input logic [IDX_W-1:0] from);
        logic [IDX_W-1:0] r;
        r = SRC_END;
        for (int k = NUM_TRK - 1; k >= 1; k--)
            if (IDX_W'(k) >= from && m[k-1]) r = IDX_W'(k);
        return r;
    endfunction

    function automatic logic signed [18:0] ext(input logic [15:0] v);
        return {{3{v[15]}}, v};
    endfunction

    function automatic logic [15:0] sat16(input logic signed [18:0] a);
        if (a > 19'sd32767)       return 16'h7fff;
        else if (a < -19'sd32768) return 16'h8000;
        else                      return a[15:0];
    endfunction

    assign stop_any  = record_stop || stop_pending;
    assign cnt_next  = record_count + 1'b1;
    assign start_src = next_src(record_mask, IDX_W'(1));
    assign first_src = next_src(mask_q, IDX_W'(1));
    assign after_src = next_src(mask_q, src_idx + IDX_W'(1));

    assign record_busy            = (state != S_IDLE);
    assign bus.record_audio_ready = (state == S_AUDIO);

    always_comb begin
        src_base = '0;
        for (int k = 1; k < NUM_TRK; k++)
            if (src_idx == IDX_W'(k)) src_base = sel_q[k*ADDR_W +: ADDR_W];
    end

    always_comb begin
        resume_state = S_SRC;
        if (mic_q)                    resume_state = S_AUDIO;
        else if (first_src == SRC_END) resume_state = S_WRITE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next   = state;
        do_start     = 1'b0;
        begin_sample = 1'b0;
        take_audio   = 1'b0;
        issue_read   = 1'b0;
        take_read    = 1'b0;
        issue_write  = 1'b0;
        take_write   = 1'b0;
        go_done      = 1'b0;
        case (state)
            S_IDLE: if (record_start) begin
                do_start = 1'b1;
                if (record_length == '0)      state_next = S_DONE;
                else if (record_mic_en)       state_next = S_AUDIO;
                else if (start_src == SRC_END) state_next = S_WRITE;
                else                          state_next = S_SRC;
            end
            S_AUDIO: begin
                if (stop_any) state_next = S_DONE;
                else if (bus.record_audio_valid) begin
                    take_audio = 1'b1;
                    state_next = (first_src == SRC_END) ? S_WRITE : S_SRC;
                end
            end
            // A stop abandons the partial sample, but only between reads.
            S_SRC: begin
                if (!bus.record_read) begin
                    if (stop_any) state_next = S_DONE;
                    else          issue_read = 1'b1;
                end else if (bus.record_sdram_finished) begin
                    take_read = 1'b1;
                    if (stop_any)                  state_next = S_DONE;
                    else if (after_src == SRC_END) state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!bus.record_write) issue_write = 1'b1;
                else if (bus.record_sdram_finished) begin
                    take_write = 1'b1;
                    if (cnt_next == len_q || stop_any) state_next = S_DONE;
                    else if (record_pause)             state_next = S_PAUSED;
                    else begin
                        begin_sample = 1'b1;
                        state_next   = resume_state;
                    end
                end
            end
            S_PAUSED: begin
                if (stop_any) state_next = S_DONE;
                else if (!record_pause) begin
                    begin_sample = 1'b1;
                    state_next   = resume_state;
                end
            end
            S_DONE: begin
                go_done    = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sel_q                <= '0;
            mask_q               <= '0;
            mic_q                <= 1'b0;
            len_q                <= '0;
            stop_pending         <= 1'b0;
            src_idx              <= '0;
            acc_l                <= '0;
            acc_r                <= '0;
            record_count         <= '0;
            record_done          <= 1'b0;
            bus.record_read      <= 1'b0;
            bus.record_write     <= 1'b0;
            bus.record_addr      <= '0;
            bus.record_writedata <= '0;
        end else begin
            record_done <= go_done;
            if (do_start || go_done)                stop_pending <= 1'b0;
            else if (record_stop && state != S_IDLE) stop_pending <= 1'b1;
            if (do_start) begin
                sel_q        <= record_select;
                mask_q       <= record_mask;
                mic_q        <= record_mic_en;
                len_q        <= record_length;
                record_count <= '0;
                src_idx      <= start_src;
                acc_l        <= '0;
                acc_r        <= '0;
            end
            if (begin_sample) begin
                acc_l   <= '0;
                acc_r   <= '0;
                src_idx <= first_src;
            end
            if (take_audio) begin
                acc_l <= acc_l + ext(bus.record_audio_data[31:16]);
                acc_r <= acc_r + ext(bus.record_audio_data[15:0]);
            end
            if (issue_read) begin
                bus.record_read <= 1'b1;
                bus.record_addr <= src_base + record_count;
            end
            if (take_read) begin
                bus.record_read <= 1'b0;
                acc_l           <= acc_l + ext(bus.record_readdata[31:16]);
                acc_r           <= acc_r + ext(bus.record_readdata[15:0]);
                src_idx         <= after_src;
            end
            if (issue_write) begin
                bus.record_write     <= 1'b1;
                bus.record_addr      <= sel_q[ADDR_W-1:0] + record_count;
                bus.record_writedata <= {sat16(acc_l), sat16(acc_r)};
            end
            if (take_write) begin
                bus.record_write <= 1'b0;
                record_count     <= cnt_next;
            end
        end
    end
endmodule

// File: doc/multitrack_record_core.md
# multitrack_record_core

Records a stereo sample stream into SDRAM, optionally overdubbing it onto up to `NUM_TRK-1` previously recorded tracks. Each output sample is the saturating sum of the enabled source tracks plus, optionally, the live microphone sample. The block sits between the top-level controller, the shared SDRAM arbiter port, and the audio codec receive path. It generalises the single-destination recorder with parametrised track count, per-track masks, a mic-bypass mixdown mode and a length limit.

## Interface
- `ADDR_W`, 23: SDRAM word address width.
- `NUM_TRK`, 3: address slots. Slot 0 is the destination; slots 1..NUM_TRK-1 are sources. Range 2..8.
- `i_clk`  in  1  single clock; all logic is on the rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `record_start`  in  1  accepted only in IDLE; latches all configuration inputs.
- `record_select`  in  NUM_TRK*ADDR_W  packed base addresses; slot k is bits [k*ADDR_W +: ADDR_W].
- `record_mask`  in  NUM_TRK-1  bit k-1 enables source slot k.
- `record_mic_en`  in  1  1 includes the live mic sample; 0 selects pure mixdown with no audio handshake.
- `record_length`  in  ADDR_W  number of samples to write.
- `record_pause`  in  1  level; freezes progress at the next sample boundary.
- `record_stop`  in  1  pulse; terminates at the next sample boundary.
- `record_done`  out  1  one-cycle pulse at completion.
- `record_busy`  out  1  high from the cycle after start is accepted until done.
- `record_count`  out  ADDR_W  samples written so far.
- `record_read`, `record_write`  out  1  SDRAM requests.
- `record_addr`  out  ADDR_W  SDRAM address.
- `record_readdata`  in  32  SDRAM read data.
- `record_writedata`  out  32  SDRAM write data.
- `record_sdram_finished`  in  1  one-cycle completion strobe from the SDRAM arbiter.
- `record_audio_ready`  out  1  audio handshake ready.
- `record_audio_data`  in  32  audio sample.
- `record_audio_valid`  in  1  audio handshake valid.

## Operation
- Sample format: [31:16] is the left channel and [15:0] is the right channel, both signed 16-bit.
- Mixing:
  - Each channel has its own 19-bit signed accumulator.
  - The accumulator is cleared at the start of each sample.
  - It adds the mic sample (if mic_en) and each enabled source.
  - On write, each channel saturates to [-32768, 32767].
- States: IDLE, AUDIO, SRC, WRITE, PAUSED, DONE.
- IDLE:
  - On `record_start`, latch select, mask, mic_en and length; clear count and the source index.
  - If length==0, go to DONE.
  - Otherwise go to AUDIO if mic_en, else to SRC.
- AUDIO:
  - `record_audio_ready`=1.
  - On valid&&ready, add data to the accumulator and go to SRC.
- SRC:
  - Iterate k=1..NUM_TRK-1; masked-off slots are skipped in zero cycles.
  - For each enabled slot, read address `base[k]+count` (mod 2^ADDR_W).
  - On finished, add readdata and advance to the next slot.
  - After the last slot, go to WRITE.
- WRITE:
  - Write the saturated sum to `base[0]+count`.
  - On finished, increment count.
  - If count==length, or a stop is pending, go to DONE.
  - Else if pause is high, go to PAUSED.
  - Else go to AUDIO (mic_en) or SRC (mixdown).
- PAUSED: all requests and ready are low. When pause drops, resume in AUDIO/SRC with the same count.
- DONE: pulse `record_done` for one cycle and return to IDLE.
- Stop handling:
  - `record_stop` in any non-IDLE state sets a sticky stop_pending flag.
  - If stop arrives in AUDIO or PAUSED with no sample captured yet, go directly to DONE with no write.
  - An in-flight SDRAM transaction always completes; an abandoned partial sample is never written.
- `record_start` while busy is ignored.

## Timing
- Reset: state=IDLE; all outputs are 0, including `record_addr`, `record_writedata` and `record_count`.
- SDRAM handshake:
  - read/write rise with a stable addr/writedata and hold until the cycle `record_sdram_finished`=1.
  - They drop on the following cycle.
  - The block never asserts read and write together.
  - Minimum gap between requests is 1 cycle.
- Audio handshake: transfer on the cycle valid&&ready. Ready drops the cycle after the transfer.
- Latency: start→first request is 2 cycles. Last finished→done pulse is 2 cycles.
- `record_count` updates on the cycle after the write's finished strobe.
- Reset asserted mid-transaction returns to IDLE in one cycle and drops requests immediately. The arbiter is responsible for discarding the orphaned request.
- Simultaneous events:
  - Pause and stop together: stop wins.
  - Stop together with the final finished strobe: done, with count=length.

## Test plan
- mic_en=1, mask=0, length=4, base0=0x100, audio 0x00010002…: 4 writes at 0x100..0x103 with unchanged data; done after the 4th finished; count=4.
- mic_en=1, mask=2'b11:
  - srcs read 0x7FFF0001 and 0x00108000, mic 0x00010001.
  - Writedata must be 0x7FFF8002: left saturates to 0x7FFF; right 0x0001+0x8000+0x0001=0x8002 in range.
  - Reads go to base1+n then base2+n before each write.
- mic_en=0, mask=2'b01, length=3: no audio_ready ever; 3 read/write pairs; mixdown is an exact copy of track 1.
- Pause held mid-sample, 20 cycles: the current write completes, then no requests for 20 cycles; resume at count+1 with no lost or duplicated address.
- Stop in AUDIO after 2 samples, length=10: no further SDRAM access; done pulse; count=2.
- length=0: done 2 cycles after start with zero SDRAM access. Base1=0x7FFFFF with length=2 wraps to 0x000000. Reset asserted mid-read: all outputs 0 the next cycle.
